// File: rtl/instr_prefetch_queue_if.sv
// Fetch-stage bundle: MMU instruction read port, decode-side opcode handshake and redirect.
// master = the prefetch queue; slave = MMU/decode side.
interface instr_prefetch_queue_if #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned CntWidth = $clog2(DEPTH) + 1;

  logic [BUS_WIDTH-1:0] mem_addr;
  logic                 mem_req;
  logic                 mem_busy;
  logic [BUS_WIDTH-1:0] mem_data;
  logic                 op_valid;
  logic [BUS_WIDTH-1:0] op_data;
  logic [BUS_WIDTH-1:0] op_pc;
  logic                 op_ready;
  logic                 flush;
  logic [BUS_WIDTH-1:0] flush_pc;
  logic [CntWidth-1:0]  q_count;

  modport master (
    output mem_addr, mem_req, op_valid, op_data, op_pc, q_count,
    input  mem_busy, mem_data, op_ready, flush, flush_pc
  );

  modport slave (
    input  mem_addr, mem_req, op_valid, op_data, op_pc, q_count,
    output mem_busy, mem_data, op_ready, flush, flush_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch: one MMU word read at a time into a PC-tagged FIFO feeding decode.
// Define IFQ_BYPASS_EN to forward a completing read straight to decode when the queue is empty.
module instr_prefetch_queue #(
  parameter int unsigned          BUS_WIDTH = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          PC_STEP   = 4
) (
  input logic                    clk,
  input logic                    reset,
  instr_prefetch_queue_if.master bus
);
  localparam int unsigned PtrWidth = $clog2(DEPTH);
  localparam int unsigned CntWidth = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

  state_e               stateQ, stateD;
  logic [BUS_WIDTH-1:0] fetchPcQ, fetchPcD;
  logic [BUS_WIDTH-1:0] memAddrQ, memAddrD;
  logic                 memReqQ, memReqD;
  logic [PtrWidth-1:0]  rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [CntWidth-1:0]  countQ, countD;
  logic [BUS_WIDTH-1:0] holdDataQ, holdPcQ;
  logic [BUS_WIDTH-1:0] qData [DEPTH];
  logic [BUS_WIDTH-1:0] qPc   [DEPTH];

  logic qEmpty, wordDone, bypassHit, push, popQueue;

  assign qEmpty   = (countQ == '0);
  assign wordDone = (stateQ == StWait) && !bus.mem_busy && !bus.flush;
`ifdef IFQ_BYPASS_EN
  assign bypassHit = qEmpty && wordDone;
`else
  assign bypassHit = 1'b0;
`endif
  assign popQueue = !qEmpty && bus.op_ready;
  // A bypassed word taken by decode this cycle never enters the queue.
  assign push     = wordDone && !(bypassHit && bus.op_ready);

  assign bus.mem_addr = memAddrQ;
  assign bus.mem_req  = memReqQ;
  assign bus.q_count  = countQ;

  always_comb begin
    bus.op_valid = !qEmpty || bypassHit;
    bus.op_data  = holdDataQ;
    bus.op_pc    = holdPcQ;
    if (!qEmpty) begin
      bus.op_data = qData[rdPtrQ];
      bus.op_pc   = qPc[rdPtrQ];
    end else if (bypassHit) begin
      bus.op_data = bus.mem_data;
      bus.op_pc   = fetchPcQ;
    end
  end

  always_comb begin
    stateD   = stateQ;
    fetchPcD = fetchPcQ;
    memAddrD = memAddrQ;
    memReqD  = memReqQ;
    unique case (stateQ)
      StIdle: begin
        if (!bus.flush && (countQ < CntWidth'(DEPTH))) begin
          memAddrD = fetchPcQ;
          memReqD  = 1'b1;
          stateD   = StIssue;
        end
      end
      StIssue: stateD = bus.flush ? StDrain : StWait;
      StWait: begin
        if (!bus.mem_busy) begin
          if (!bus.flush) fetchPcD = fetchPcQ + BUS_WIDTH'(PC_STEP);
          memReqD = 1'b0;
          stateD  = StIdle;
        end else if (bus.flush) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        if (!bus.mem_busy) begin
          memReqD = 1'b0;
          stateD  = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
    // Redirect overrides any increment; the latest flush_pc wins.
    if (bus.flush) fetchPcD = bus.flush_pc;
  end

  always_comb begin
    countD = countQ;
    rdPtrD = rdPtrQ;
    wrPtrD = wrPtrQ;
    if (bus.flush) begin
      countD = '0;
      rdPtrD = '0;
      wrPtrD = '0;
    end else begin
      if (push)     wrPtrD = wrPtrQ + 1'b1;
      if (popQueue) rdPtrD = rdPtrQ + 1'b1;
      if (push && !popQueue)      countD = countQ + 1'b1;
      else if (!push && popQueue) countD = countQ - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= StIdle;
      fetchPcQ  <= RESET_PC;
      memAddrQ  <= '0;
      memReqQ   <= 1'b0;
      rdPtrQ    <= '0;
      wrPtrQ    <= '0;
      countQ    <= '0;
      holdDataQ <= '0;
      holdPcQ   <= '0;
    end else begin
      stateQ   <= stateD;
      fetchPcQ <= fetchPcD;
      memAddrQ <= memAddrD;
      memReqQ  <= memReqD;
      rdPtrQ   <= rdPtrD;
      wrPtrQ   <= wrPtrD;
      countQ   <= countD;
      // Remember what decode last saw so an empty queue keeps presenting it.
      if (bus.op_valid) begin
        holdDataQ <= bus.op_data;
        holdPcQ   <= bus.op_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      qData[wrPtrQ] <= bus.mem_data;
      qPc[wrPtrQ]   <= fetchPcQ;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a 2-busy-cycle MMU returning addr^0xA5A5A5A5.
// Build with or without IFQ_BYPASS_EN; the bypass timing check follows the same macro.
module tb_instr_prefetch_queue;
  localparam logic [31:0] Key = 32'hA5A5A5A5;

  logic clk;
  logic reset;
  int   testsRun  = 0;
  int   failCount = 0;
  int   busyCnt   = 0;

  instr_prefetch_queue_if #(.BUS_WIDTH(32), .DEPTH(4)) ifc ();

  instr_prefetch_queue #(
    .BUS_WIDTH(32),
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // MMU: busy for two cycles after the request is seen, then data for one cycle.
  initial begin
    ifc.mem_busy = 1'b0;
    ifc.mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.mem_req) begin
        if (busyCnt < 2) begin
          ifc.mem_busy = 1'b1;
          busyCnt++;
        end else begin
          ifc.mem_busy = 1'b0;
          ifc.mem_data = ifc.mem_addr ^ Key;
        end
      end else begin
        ifc.mem_busy = 1'b0;
        busyCnt      = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (ifc.op_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(ifc.op_valid), 32'd1);
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    while (ifc.mem_req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(ifc.mem_req), 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int   n;
    logic sawReq;
    logic [31:0] pc;

    reset        = 1'b0;
    ifc.op_ready = 1'b0;
    ifc.flush    = 1'b0;
    ifc.flush_pc = '0;

    // Reset values
    @(negedge clk);
    check("rst_mem_req",  32'(ifc.mem_req),  32'd0);
    check("rst_mem_addr", ifc.mem_addr,      32'd0);
    check("rst_op_valid", 32'(ifc.op_valid), 32'd0);
    check("rst_op_data",  ifc.op_data,       32'd0);
    check("rst_op_pc",    ifc.op_pc,         32'd0);
    check("rst_q_count",  32'(ifc.q_count),  32'd0);

    // Streaming with decode always ready: each word shows exactly once
    reset        = 1'b1;
    ifc.op_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 32'(k * 4);
      waitValid($sformatf("stream%0d", k));
      check($sformatf("stream%0d_pc", k),   ifc.op_pc,   pc);
      check($sformatf("stream%0d_data", k), ifc.op_data, pc ^ Key);
      @(negedge clk);
      check($sformatf("stream%0d_once", k), 32'(ifc.op_valid), 32'd0);
    end

    // Back-pressure: queue fills to DEPTH and fetch stops
    ifc.op_ready = 1'b0;
    doReset();
    sawReq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c >= 20 && ifc.mem_req) sawReq = 1'b1;
    end
    check("full_count",  32'(ifc.q_count), 32'd4);
    check("full_no_req", 32'(sawReq),      32'd0);
    ifc.op_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_valid", k), 32'(ifc.op_valid), 32'd1);
      check($sformatf("drain%0d_pc", k),    ifc.op_pc,         32'(k * 4));
      @(negedge clk);
    end
    waitValid("resume");
    check("resume_pc",   ifc.op_pc,   32'h10);
    check("resume_data", ifc.op_data, 32'h10 ^ Key);

    // Flush while the read of 0x8 is in WAIT
    doReset();
    waitValid("fw0");
    check("fw0_pc", ifc.op_pc, 32'h0);
    @(negedge clk);
    waitValid("fw4");
    check("fw4_pc", ifc.op_pc, 32'h4);
    n = 0;
    while (!(ifc.mem_req === 1'b1 && ifc.mem_addr === 32'h8) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("fw_issue8", ifc.mem_addr, 32'h8);
    @(negedge clk);
    ifc.flush    = 1'b1;
    ifc.flush_pc = 32'h100;
    @(negedge clk);
    ifc.flush = 1'b0;
    check("fw_valid_after", 32'(ifc.op_valid), 32'd0);
    check("fw_count_after", 32'(ifc.q_count),  32'd0);
    waitValid("fw_next");
    check("fw_next_pc",   ifc.op_pc,   32'h100);
    check("fw_next_data", ifc.op_data, 32'h100 ^ Key);

    // Flush and pop together with three queued
    ifc.op_ready = 1'b0;
    doReset();
    n = 0;
    while (ifc.q_count !== 3'd3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("fp_count3", 32'(ifc.q_count),  32'd3);
    check("fp_valid",  32'(ifc.op_valid), 32'd1);
    ifc.op_ready = 1'b1;
    ifc.flush    = 1'b1;
    ifc.flush_pc = 32'h200;
    @(negedge clk);
    ifc.flush = 1'b0;
    check("fp_count0",    32'(ifc.q_count),  32'd0);
    check("fp_valid0",    32'(ifc.op_valid), 32'd0);
    waitValid("fp_next");
    check("fp_next_pc",   ifc.op_pc,   32'h200);
    check("fp_next_data", ifc.op_data, 32'h200 ^ Key);

    // Asynchronous reset in the middle of a read
    ifc.op_ready = 1'b0;
    @(negedge clk);
    waitReq("ar");
    @(negedge clk);
    check("ar_pre_valid", 32'(ifc.op_valid), 32'd1);
    check("ar_pre_req",   32'(ifc.mem_req),  32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req",   32'(ifc.mem_req),  32'd0);
    check("ar_valid", 32'(ifc.op_valid), 32'd0);
    check("ar_count", 32'(ifc.q_count),  32'd0);
    @(negedge clk);
    reset        = 1'b1;
    ifc.op_ready = 1'b1;
    waitValid("ar_restart");
    check("ar_restart_pc",   ifc.op_pc,   32'h0);
    check("ar_restart_data", ifc.op_data, Key);

    // Fetch-to-decode latency at the completion cycle
    doReset();
    n = 0;
    while (!(ifc.mem_req === 1'b1 && ifc.mem_busy === 1'b0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("lat_done", 32'(ifc.mem_busy), 32'd0);
`ifdef IFQ_BYPASS_EN
    check("lat_valid_now", 32'(ifc.op_valid), 32'd1);
    check("lat_pc_now",    ifc.op_pc,         32'h0);
    check("lat_data_now",  ifc.op_data,       Key);
    check("lat_count_now", 32'(ifc.q_count),  32'd0);
    @(negedge clk);
    check("lat_valid_next", 32'(ifc.op_valid), 32'd0);
    check("lat_count_next", 32'(ifc.q_count),  32'd0);
`else
    check("lat_valid_now", 32'(ifc.op_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_next", 32'(ifc.op_valid), 32'd1);
    check("lat_pc_next",    ifc.op_pc,         32'h0);
    check("lat_data_next",  ifc.op_data,       Key);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
